// File: rtl/calc_sequencer.sv
// ============================================================================
// calc_sequencer : key-driven front end for the signed 32-bit calculate datapath
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_sequencer #(
   parameter int DIGITS_MAX  = 9,
   parameter int EXEC_CYCLES = 2
) (
   input  logic               sw_clk,
   input  logic               rst,
   input  logic               key_valid,
   input  logic [4:0]         key_code,
   output logic               key_ready,
   output logic signed [31:0] operand1,
   output logic signed [31:0] operand2,
   output logic [2:0]         operator,
   output logic               calc_start,
   input  logic signed [31:0] calc_result,
   output logic signed [31:0] display_value,
   output logic               err,
   output logic               busy,
   output logic [2:0]         state_out
);

   localparam int CW = $clog2(DIGITS_MAX + 1);
   localparam int EW = $clog2(EXEC_CYCLES + 1);
   localparam logic [CW-1:0] C_DMAX  = CW'(DIGITS_MAX);
   localparam logic [EW-1:0] C_ELAST = EW'(EXEC_CYCLES);

   typedef enum logic [2:0] {
      S_OP1  = 3'd0,
      S_OP2  = 3'd1,
      S_EXEC = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t             state, state_n;
   logic signed [31:0] op1_n, op2_n;
   logic [2:0]         opr_n, pend_op, pend_op_n;
   logic               pend, pend_n;
   logic [31:0]        mag, mag_n;
   logic               sign, sign_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic [EW-1:0]      ecnt, ecnt_n;

   logic               accept, is_digit, is_op, is_eq, is_clr, is_neg, can_add, div_zero;
   logic [2:0]         key_op;
   logic [31:0]        digit_mag;
   logic signed [31:0] digit_val;

   assign key_ready = (state != S_EXEC);
   assign busy      = (state == S_EXEC);
   assign err       = (state == S_ERR);
   assign state_out = state;

   assign accept    = key_valid && key_ready;
   assign is_digit  = (key_code <= 5'd9);
   assign is_op     = (key_code >= 5'd10) && (key_code <= 5'd14);
   assign is_eq     = (key_code == 5'd15);
   assign is_clr    = (key_code == 5'd16);
   assign is_neg    = (key_code == 5'd17);
   // Op keys 10..14 have low bits 2..6, so subtracting 2 yields the op code.
   assign key_op    = key_code[2:0] - 3'd2;
   assign can_add   = (cnt < C_DMAX);
   assign digit_mag = mag * 32'd10 + {27'd0, key_code};
   assign digit_val = sign ? -$signed(digit_mag) : $signed(digit_mag);
   assign div_zero  = ((operator == 3'd3) || (operator == 3'd4)) && (operand2 == 32'sd0);

   always_comb begin
      state_n    = state;
      op1_n      = operand1;
      op2_n      = operand2;
      opr_n      = operator;
      pend_n     = pend;
      pend_op_n  = pend_op;
      mag_n      = mag;
      sign_n     = sign;
      cnt_n      = cnt;
      ecnt_n     = '0;
      calc_start = 1'b0;

      if (accept && is_clr) begin
         state_n   = S_OP1;
         op1_n     = '0;
         op2_n     = '0;
         opr_n     = '0;
         pend_n    = 1'b0;
         pend_op_n = '0;
         mag_n     = '0;
         sign_n    = 1'b0;
         cnt_n     = '0;
      end else begin
         case (state)
            S_OP1: if (accept) begin
               if (is_digit) begin
                  if (can_add) begin
                     mag_n = digit_mag;
                     cnt_n = cnt + CW'(1);
                     op1_n = digit_val;
                  end
               end else if (is_neg) begin
                  sign_n = ~sign;
                  op1_n  = -operand1;
               end else if (is_op) begin
                  opr_n   = key_op;
                  op2_n   = '0;
                  mag_n   = '0;
                  sign_n  = 1'b0;
                  cnt_n   = '0;
                  state_n = S_OP2;
               end
            end
            S_OP2: if (accept) begin
               if (is_digit) begin
                  if (can_add) begin
                     mag_n = digit_mag;
                     cnt_n = cnt + CW'(1);
                     op2_n = digit_val;
                  end
               end else if (is_neg) begin
                  sign_n = ~sign;
                  op2_n  = -operand2;
               end else if (is_op) begin
                  if (cnt == '0) begin
                     opr_n = key_op;
                  end else begin
                     pend_n    = 1'b1;
                     pend_op_n = key_op;
                     state_n   = S_EXEC;
                  end
               end else if (is_eq && (cnt != '0)) begin
                  pend_n  = 1'b0;
                  state_n = S_EXEC;
               end
            end
            S_EXEC: begin
               if ((ecnt == '0) && div_zero) begin
                  state_n = S_ERR;
               end else begin
                  calc_start = (ecnt == '0);
                  if (ecnt == C_ELAST) begin
                     op1_n = calc_result;
                     if (pend) begin
                        opr_n   = pend_op;
                        pend_n  = 1'b0;
                        op2_n   = '0;
                        mag_n   = '0;
                        sign_n  = 1'b0;
                        cnt_n   = '0;
                        state_n = S_OP2;
                     end else begin
                        state_n = S_DONE;
                     end
                  end else begin
                     ecnt_n = ecnt + EW'(1);
                  end
               end
            end
            S_DONE: if (accept) begin
               if (is_digit) begin
                  mag_n   = {27'd0, key_code};
                  sign_n  = 1'b0;
                  cnt_n   = CW'(1);
                  op1_n   = {27'd0, key_code};
                  state_n = S_OP1;
               end else if (is_op) begin
                  opr_n   = key_op;
                  op2_n   = '0;
                  mag_n   = '0;
                  sign_n  = 1'b0;
                  cnt_n   = '0;
                  state_n = S_OP2;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge sw_clk or negedge rst) begin
      if (!rst) begin
         state    <= S_OP1;
         operand1 <= '0;
         operand2 <= '0;
         operator <= '0;
         pend     <= 1'b0;
         pend_op  <= '0;
         mag      <= '0;
         sign     <= 1'b0;
         cnt      <= '0;
         ecnt     <= '0;
      end else begin
         state    <= state_n;
         operand1 <= op1_n;
         operand2 <= op2_n;
         operator <= opr_n;
         pend     <= pend_n;
         pend_op  <= pend_op_n;
         mag      <= mag_n;
         sign     <= sign_n;
         cnt      <= cnt_n;
         ecnt     <= ecnt_n;
      end
   end

   // The operand under entry is shown while typing; S_EXEC keeps the last entered value.
   always_comb begin
      display_value = '0;
      case (state)
         S_OP1:   display_value = operand1;
         S_OP2:   display_value = (cnt != '0) ? operand2 : operand1;
         S_EXEC:  display_value = operand2;
         S_DONE:  display_value = operand1;
         default: display_value = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_calc_sequencer.sv
// ============================================================================
// tb_calc_sequencer : directed-vector bench for calc_sequencer
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_sequencer;

   localparam logic [4:0] K_ADD = 5'd10, K_SUB = 5'd11, K_MUL = 5'd12, K_DIV = 5'd13;
   localparam logic [4:0] K_MOD = 5'd14, K_EQ = 5'd15, K_CLR = 5'd16, K_NEG = 5'd17;

   logic               sw_clk = 1'b0;
   logic               rst;
   logic               key_valid;
   logic [4:0]         key_code;
   logic               key_ready;
   logic signed [31:0] operand1, operand2, calc_result, display_value;
   logic [2:0]         operator, state_out;
   logic               calc_start, err, busy;

   int vectors = 0;
   int errors  = 0;
   int starts  = 0;
   int busy_cycles = 0;
   logic signed [31:0] st_op1, st_op2;
   logic [2:0]         st_opr;

   calc_sequencer #(.DIGITS_MAX(9), .EXEC_CYCLES(2)) dut (
      .sw_clk(sw_clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .key_ready(key_ready), .operand1(operand1), .operand2(operand2), .operator(operator),
      .calc_start(calc_start), .calc_result(calc_result), .display_value(display_value),
      .err(err), .busy(busy), .state_out(state_out)
   );

   always #5 sw_clk = ~sw_clk;

   // Behavioural datapath
   always_comb begin
      case (operator)
         3'd0:    calc_result = operand1 + operand2;
         3'd1:    calc_result = operand1 - operand2;
         3'd2:    calc_result = operand1 * operand2;
         3'd3:    calc_result = (operand2 == 0) ? 32'sd0 : operand1 / operand2;
         3'd4:    calc_result = (operand2 == 0) ? 32'sd0 : operand1 % operand2;
         default: calc_result = 32'sd0;
      endcase
   end

   always @(posedge sw_clk) begin
      if (calc_start) begin
         starts++;
         st_op1 = operand1;
         st_op2 = operand2;
         st_opr = operator;
      end
      if (busy) busy_cycles++;
   end

   task automatic press(input logic [4:0] c);
      int n = 0;
      @(negedge sw_clk);
      key_valid = 1'b1;
      key_code  = c;
      while (!key_ready && n < 50) begin
         @(negedge sw_clk);
         n++;
      end
      if (n >= 50) begin
         vectors++; errors++;
         $display("FAIL press_timeout: key %0d key_ready=%0b required 1", c, key_ready);
      end
      @(posedge sw_clk);
      #1;
      key_valid = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] s, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge sw_clk);
         if (state_out == s) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; key_valid = 1'b0; key_code = 5'd0;
      #2 rst = 1'b0;
      #2;
      vectors++; if (state_out !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_out); end
      vectors++; if (operand1 !== 32'sd0 || operand2 !== 32'sd0 || operator !== 3'd0) begin errors++;
         $display("FAIL reset_operands: got %0d %0d %0d want 0 0 0", operand1, operand2, operator); end
      vectors++; if ({calc_start, err, busy} !== 3'b000 || display_value !== 32'sd0) begin errors++;
         $display("FAIL reset_flags: got start/err/busy=%b disp=%0d want 000 0", {calc_start, err, busy}, display_value); end
      repeat (2) @(negedge sw_clk);
      rst = 1'b1;
      @(negedge sw_clk);
      vectors++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", key_ready); end
   endtask

   task automatic test_add;
      bit ok;
      int s0;
      press(5'd1); press(5'd2); press(K_ADD);
      vectors++; if (operand1 !== 32'sd12 || state_out !== 3'd1) begin errors++;
         $display("FAIL add_op1: got op1=%0d state=%0d want 12 1", operand1, state_out); end
      press(5'd3); press(5'd4);
      vectors++; if (display_value !== 32'sd34) begin errors++; $display("FAIL add_disp_op2: got %0d want 34", display_value); end
      s0 = starts; busy_cycles = 0;
      press(K_EQ);
      wait_state(3'd3, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL add_done_timeout: state=%0d want 3", state_out); end
      vectors++; if (starts - s0 !== 1 || st_op1 !== 32'sd12 || st_op2 !== 32'sd34 || st_opr !== 3'd0) begin errors++;
         $display("FAIL add_launch: got starts=%0d op1=%0d op2=%0d opr=%0d want 1 12 34 0", starts - s0, st_op1, st_op2, st_opr); end
      vectors++; if (busy_cycles !== 3) begin errors++; $display("FAIL add_exec_len: got %0d cycles want 3", busy_cycles); end
      vectors++; if (display_value !== 32'sd46) begin errors++; $display("FAIL add_result: got %0d want 46", display_value); end
   endtask

   task automatic test_done_chain;
      bit ok;
      press(K_SUB);
      vectors++; if (state_out !== 3'd1 || operand1 !== 32'sd46 || operator !== 3'd1) begin errors++;
         $display("FAIL donechain_op: got state=%0d op1=%0d opr=%0d want 1 46 1", state_out, operand1, operator); end
      press(5'd6); press(K_EQ);
      wait_state(3'd3, ok);
      vectors++; if (!ok || display_value !== 32'sd40) begin errors++;
         $display("FAIL donechain_result: got %0d (state %0d) want 40", display_value, state_out); end
   endtask

   task automatic test_divzero;
      bit ok;
      int s0;
      press(K_CLR);
      s0 = starts;
      press(5'd7); press(K_DIV); press(5'd0); press(K_EQ);
      wait_state(3'd4, ok);
      vectors++; if (!ok || err !== 1'b1 || display_value !== 32'sd0) begin errors++;
         $display("FAIL div0_trap: got state=%0d err=%0b disp=%0d want 4 1 0", state_out, err, display_value); end
      vectors++; if (starts != s0) begin errors++; $display("FAIL div0_nostart: got %0d pulses want 0", starts - s0); end
      press(5'd5); press(K_ADD);
      vectors++; if (state_out !== 3'd4 || err !== 1'b1) begin errors++;
         $display("FAIL div0_sticky: got state=%0d err=%0b want 4 1", state_out, err); end
      press(K_CLR);
      vectors++; if (state_out !== 3'd0 || err !== 1'b0 || display_value !== 32'sd0 || operand1 !== 32'sd0) begin errors++;
         $display("FAIL div0_clr: got state=%0d err=%0b disp=%0d op1=%0d want 0 0 0 0", state_out, err, display_value, operand1); end
   endtask

   task automatic test_chain;
      bit ok;
      int s0;
      press(K_CLR);
      s0 = starts;
      press(5'd5); press(K_MUL); press(5'd6); press(K_SUB);
      wait_state(3'd1, ok);
      vectors++; if (!ok || operand1 !== 32'sd30 || operand2 !== 32'sd0 || operator !== 3'd1 || display_value !== 32'sd30) begin errors++;
         $display("FAIL chain_mid: got op1=%0d op2=%0d opr=%0d disp=%0d want 30 0 1 30", operand1, operand2, operator, display_value); end
      press(5'd1); press(5'd0); press(K_EQ);
      wait_state(3'd3, ok);
      vectors++; if (!ok || display_value !== 32'sd20 || starts - s0 !== 2) begin errors++;
         $display("FAIL chain_final: got disp=%0d starts=%0d want 20 2", display_value, starts - s0); end
   endtask

   task automatic test_op_replace;
      bit ok;
      press(K_CLR);
      press(5'd8); press(K_EQ);
      vectors++; if (state_out !== 3'd0 || operand1 !== 32'sd8) begin errors++;
         $display("FAIL eq_in_op1: got state=%0d op1=%0d want 0 8", state_out, operand1); end
      press(K_ADD); press(K_MUL); press(K_EQ);
      vectors++; if (state_out !== 3'd1 || operator !== 3'd2 || display_value !== 32'sd8) begin errors++;
         $display("FAIL op_replace: got state=%0d opr=%0d disp=%0d want 1 2 8", state_out, operator, display_value); end
      press(5'd3); press(K_EQ);
      wait_state(3'd3, ok);
      vectors++; if (!ok || display_value !== 32'sd24) begin errors++; $display("FAIL op_replace_result: got %0d want 24", display_value); end
   endtask

   task automatic test_neg_mod;
      bit ok;
      press(K_CLR);
      press(5'd9); press(K_NEG);
      vectors++; if (operand1 !== -32'sd9 || display_value !== -32'sd9) begin errors++;
         $display("FAIL neg_op1: got op1=%0d disp=%0d want -9 -9", operand1, display_value); end
      press(K_MOD); press(5'd4); press(K_EQ);
      wait_state(3'd3, ok);
      vectors++; if (!ok || display_value !== -32'sd1) begin errors++; $display("FAIL neg_mod_result: got %0d want -1", display_value); end
   endtask

   task automatic test_digits;
      press(K_CLR);
      for (int i = 0; i < 10; i++) press(5'd9);
      vectors++; if (operand1 !== 32'sd999999999 || display_value !== 32'sd999999999) begin errors++;
         $display("FAIL digit_limit: got %0d want 999999999", operand1); end
   endtask

   task automatic test_exec_hold;
      press(K_CLR);
      press(5'd2); press(K_ADD); press(5'd3); press(K_EQ);
      @(negedge sw_clk);
      vectors++; if (key_ready !== 1'b0 || busy !== 1'b1) begin errors++;
         $display("FAIL exec_ready: got ready=%0b busy=%0b want 0 1", key_ready, busy); end
      press(5'd4);
      vectors++; if (state_out !== 3'd0 || operand1 !== 32'sd4 || display_value !== 32'sd4) begin errors++;
         $display("FAIL exec_held_key: got state=%0d op1=%0d disp=%0d want 0 4 4", state_out, operand1, display_value); end
   endtask

   task automatic test_reset_mid_exec;
      press(K_CLR);
      press(5'd1); press(K_ADD); press(5'd1); press(K_EQ);
      @(posedge sw_clk);
      #2 rst = 1'b0;
      #1;
      vectors++; if (state_out !== 3'd0 || operand1 !== 32'sd0 || operand2 !== 32'sd0 || operator !== 3'd0 ||
                     {calc_start, err, busy} !== 3'b000 || display_value !== 32'sd0) begin errors++;
         $display("FAIL rst_mid_exec: got state=%0d op1=%0d op2=%0d opr=%0d flags=%b disp=%0d want all 0",
                  state_out, operand1, operand2, operator, {calc_start, err, busy}, display_value); end
      repeat (2) @(negedge sw_clk);
      rst = 1'b1;
      repeat (4) @(negedge sw_clk);
      vectors++; if (state_out !== 3'd0 || operand1 !== 32'sd0 || key_ready !== 1'b1) begin errors++;
         $display("FAIL rst_no_capture: got state=%0d op1=%0d ready=%0b want 0 0 1", state_out, operand1, key_ready); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_done_chain();
      test_divzero();
      test_chain();
      test_op_replace();
      test_neg_mod();
      test_digits();
      test_exec_hold();
      test_reset_mid_exec();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
